// File: rtl/dmem_ls.sv
// Load/store data memory with a request/response handshake, wait states and sub-word accesses.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of forcing them aligned.
module dmem_ls #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  CntInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] mem_q [Depth] = '{default: '0};

    logic                  accept;
    logic                  access;
    logic                  mem_we;
    logic                  eff_we;
    logic [1:0]            eff_size;
    logic                  eff_uns;
    logic [31:0]           eff_addr;
    logic [31:0]           eff_wdata;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  fault;
    logic [31:0]           rd_word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ld_data;
    logic [3:0]            be;
    logic [31:0]           wd;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign accept     = req_valid && req_ready;

    // The access edge is the edge entering RESP; with no wait states it coincides with accept.
    assign access = (state_q == StIdle && accept && WAIT_STATES == 0) ||
                    (state_q == StWait && cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                fault_q <= fault;
                rdata_q <= (fault || eff_we) ? 32'd0 : ld_data;
            end
        end
    end

    // Live request fields in IDLE (zero-wait access), latched fields afterwards.
    always_comb begin
        if (state_q == StIdle) begin
            eff_we    = req_we;
            eff_size  = req_size;
            eff_uns   = req_unsigned;
            eff_addr  = req_addr;
            eff_wdata = req_wdata;
        end else begin
            eff_we    = we_q;
            eff_size  = size_q;
            eff_uns   = uns_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
        end
    end

    always_comb begin
        idx  = eff_addr[ADDR_WIDTH+1:2];
        lane = eff_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
        fault = (|eff_addr[31:ADDR_WIDTH+2]) ||
                (eff_size == 2'b01 && lane[0]) ||
                (eff_size == 2'b10 && lane != 2'b00) ||
                (eff_size == 2'b11);
`else
        fault = |eff_addr[31:ADDR_WIDTH+2];
`endif
        rd_word  = mem_q[idx];
        byte_sel = rd_word[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (eff_size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wd      = {4{eff_wdata[7:0]}};
                ld_data = eff_uns ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wd      = {2{eff_wdata[15:0]}};
                ld_data = eff_uns ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                be      = 4'b1111;
                wd      = eff_wdata;
                ld_data = rd_word;
            end
        endcase
    end

    // Gated by rst_n so a zero-wait store presented during reset cannot reach memory.
    assign mem_we = access && eff_we && !fault && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wd[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ls.sv
// Directed bench for dmem_ls: byte-array reference model checked every cycle, plus literal pins.
module tb_dmem_ls;

    localparam int unsigned WS = 1;
    localparam int unsigned AW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    dmem_ls #(
        .ADDR_WIDTH (AW),
        .WAIT_STATES(WS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [7:0]  bmem [4096];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] last_rd = 32'd0;
    logic [31:0] last_mrd = 32'd0;
    logic        last_f = 1'b0;
    logic        last_mf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference behaviour from the byte-level view of memory.
    task automatic model_exec(input req_t r, output logic [31:0] rd, output logic f);
        int          sz;
        int          base;
        logic [31:0] val;
        sz = (r.size == 2'b00) ? 1 : (r.size == 2'b01) ? 2 : 4;
        f  = (r.addr >= 32'(4 * (2 ** AW)));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (r.size == 2'b11 || (r.addr % sz) != 0) f = 1'b1;
`endif
        rd = 32'd0;
        if (!f) begin
            base = int'(r.addr[AW+1:0]) / sz * sz;
            if (r.we) begin
                for (int i = 0; i < sz; i++) bmem[base+i] = r.wdata[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < sz; i++) val = val | (32'(bmem[base+i]) << (8 * i));
                if (sz < 4 && !r.uns && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
                rd = val;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] mrd;
        logic        mf;
        if (!rst_n) begin
            pend.delete();
            chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("rst req_ready", {31'd0, req_ready}, 32'd1);
            chk("rst resp_rdata", resp_rdata, 32'd0);
            chk("rst resp_fault", {31'd0, resp_fault}, 32'd0);
        end else if (pend.size() != 0 && cyc == pend[0].due) begin
            model_exec(pend[0], mrd, mf);
            chk("resp_valid at due", {31'd0, resp_valid}, 32'd1);
            chk("resp_rdata", resp_rdata, mrd);
            chk("resp_fault", {31'd0, resp_fault}, {31'd0, mf});
            last_rd  = resp_rdata;
            last_f   = resp_fault;
            last_mrd = mrd;
            last_mf  = mf;
            void'(pend.pop_front());
        end else begin
            chk("resp_valid idle", {31'd0, resp_valid}, 32'd0);
        end
    end

    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        r = '{we: we, size: size, uns: uns, addr: addr, wdata: wdata, due: cyc + 1 + int'(WS)};
        pend.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (pend.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (pend.size() != 0) begin
            total++;
            bad++;
            $display("FAIL response timeout: got=none expected=resp_valid for addr %h", addr);
            pend.delete();
        end
    endtask

    task automatic lit(input string name, input logic [31:0] exp_rd, input logic exp_f);
        chk({name, " dut rdata"}, last_rd, exp_rd);
        chk({name, " dut fault"}, {31'd0, last_f}, {31'd0, exp_f});
        chk({name, " model rdata"}, last_mrd, exp_rd);
        chk({name, " model fault"}, {31'd0, last_mf}, {31'd0, exp_f});
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) bmem[i] = 8'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ready after reset", {31'd0, req_ready}, 32'd1);

        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h8765_4321);
        lit("sw 0x10", 32'd0, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        lit("lw 0x10", 32'h8765_4321, 1'b0);
        txn(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        lit("lb 0x13", 32'hFFFF_FF87, 1'b0);
        txn(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
        lit("lbu 0x13", 32'h0000_0087, 1'b0);
        txn(1'b0, 2'b01, 1'b0, 32'h10, 32'd0);
        lit("lh 0x10", 32'h0000_4321, 1'b0);
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
        lit("lh 0x12", 32'hFFFF_8765, 1'b0);
        txn(1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
        lit("lhu 0x12", 32'h0000_8765, 1'b0);

        txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_56AA);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        lit("lw after sb", 32'h8765_AA21, 1'b0);

        txn(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344);
        txn(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF);
        lit("sw out of range", 32'd0, 1'b1);
        txn(1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
        lit("lw 0x0 no alias", 32'h1122_3344, 1'b0);
        txn(1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'd0);
        lit("lw out of range", 32'd0, 1'b1);

        txn(1'b0, 2'b10, 1'b0, 32'h12, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        lit("lw 0x12 misaligned", 32'd0, 1'b1);
`else
        lit("lw 0x12 forced aligned", 32'h8765_AA21, 1'b0);
`endif

        // Abort a store to 0x20 while it sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'h5;
        pend.push_back('{we: 1'b1, size: 2'b10, uns: 1'b0, addr: 32'h20, wdata: 32'h5,
                         due: cyc + 1 + int'(WS)});
        @(negedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pend.delete();
        #1 chk("ready after mid reset", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0);
        lit("lw 0x20 after abort", 32'd0, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
